vga_tile_renderer: RTL and testbench

- Sits directly downstream of the VGA timing generator and consumes its `vaddr`, `vga_DA`, `vga_HS` and `vga_VS`.
- Owns a dual-port tile RAM: the RISC-V core writes and reads it over a simple memory-mapped port, and the video side reads it once per pixel clock.
- Produces RGB444 pixel data with sync and data-active realigned to account for the RAM read latency.
- Keeps a frame counter that drives a per-tile blink attribute.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_tile_ram.sv | 28 ++
 rtl/vga_tile_renderer.sv | 84 ++++++++
 tb/tb_vga_tile_renderer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the tile renderer: RGB444 colour, tile word
// layout and the visible 20x15 tile grid.
package vga_pkg;

    localparam int TILE_COLS    = 20;
    localparam int TILE_ROWS    = 15;
    localparam int TILE_VISIBLE = TILE_COLS * TILE_ROWS;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        logic [6:0] reserved;
        logic       blink;
        rgb444_t    alternate;
        rgb444_t    primary;
    } tile_word_t;

    // Alternate colour only during the "on" half of the blink period.
    function automatic rgb444_t tile_colour(input tile_word_t w, input logic phase);
        return (w.blink && phase) ? w.alternate : w.primary;
    endfunction

endpackage

// File: rtl/vga_tile_ram.sv
// True dual-port tile RAM, single clock, read-before-write on both ports.
// Port A is the CPU read/write port, port B the video read port.
module vga_tile_ram
    import vga_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     we_a,
    input  logic [$clog2(DEPTH)-1:0] addr_a,
    input  logic [31:0]              wdata_a,
    output logic [31:0]              rdata_a,
    input  logic [$clog2(DEPTH)-1:0] addr_b,
    output tile_word_t               rdata_b
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= wdata_a;
        rdata_a <= mem[addr_a];
    end

    always_ff @(posedge clk) begin
        rdata_b <= tile_word_t'(mem[addr_b]);
    end

endmodule

// File: rtl/vga_tile_renderer.sv
// Tile renderer: looks up the tile word for each pixel, applies blink and
// blanking, and delays sync/DA by one cycle to line up with the RAM latency.
module vga_tile_renderer
    import vga_pkg::*;
#(
    parameter int DEPTH     = 512,
    parameter bit HPULSEN   = 1'b1,
    parameter bit VPULSEN   = 1'b1,
    parameter int BLINK_BIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] vaddr,
    input  logic        vga_DA,
    input  logic        vga_HS,
    input  logic        vga_VS,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic [3:0]  out_R,
    output logic [3:0]  out_G,
    output logic [3:0]  out_B,
    output logic        out_HS,
    output logic        out_VS,
    output logic        out_DA
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] ram_cpu_q;
    tile_word_t  tile_q;
    rgb444_t     colour;
    logic        rd_valid;
    logic        vs_prev;
    logic [4:0]  frame_cnt;
    logic        unused_bits;

    vga_tile_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .we_a    (cpu_we),
        .addr_a  (cpu_addr[AW+1:2]),
        .wdata_a (cpu_wdata),
        .rdata_a (ram_cpu_q),
        .addr_b  (vaddr[AW-1:0]),
        .rdata_b (tile_q)
    );

    // Out-of-range indices simply wrap; DA masks them.
    assign unused_bits = ^{vaddr[31:AW], cpu_addr[31:AW+2], cpu_addr[1:0]};

    assign colour = tile_colour(tile_q, frame_cnt[BLINK_BIT]);

    // The RAM output register has no reset, so gate it until the first edge
    // after reset has loaded it with a real read.
    assign cpu_rdata = rd_valid ? ram_cpu_q : 32'h0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_HS    <= HPULSEN;
            out_VS    <= VPULSEN;
            out_DA    <= 1'b0;
            out_R     <= 4'h0;
            out_G     <= 4'h0;
            out_B     <= 4'h0;
            vs_prev   <= VPULSEN;
            frame_cnt <= 5'd0;
            rd_valid  <= 1'b0;
        end else begin
            out_HS   <= vga_HS;
            out_VS   <= vga_VS;
            out_DA   <= vga_DA;
            vs_prev  <= out_VS;
            rd_valid <= 1'b1;
            out_R    <= vga_DA ? colour.r : 4'h0;
            out_G    <= vga_DA ? colour.g : 4'h0;
            out_B    <= vga_DA ? colour.b : 4'h0;
            // Count idle-to-active edges of the registered VS.
            if (vs_prev == VPULSEN && out_VS != VPULSEN)
                frame_cnt <= frame_cnt + 5'd1;
        end
    end

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Self-checking bench for vga_tile_renderer: per-cycle scoreboard for the
// video and CPU read paths, table-driven pixel vectors plus corner sequences.
module tb_vga_tile_renderer;

    typedef struct packed {
        logic [11:0] rgb;
        logic        da;
        logic        hs;
        logic        vs;
    } vexp_t;

    typedef struct packed {
        logic [31:0] d;
        logic        chk;
    } cexp_t;

    typedef struct {
        logic [31:0] va;
        logic        da;
        logic [11:0] rgb;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] vaddr = 32'h0;
    logic        vga_DA = 1'b0, vga_HS = 1'b1, vga_VS = 1'b1;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
    logic [31:0] cpu_rdata;
    logic [3:0]  out_R, out_G, out_B;
    logic        out_HS, out_VS, out_DA;

    int          total = 0;
    int          bad = 0;
    int          fcnt = 0;
    logic [31:0] model [512];
    logic        p_da = 1'b0, p_hs = 1'b1, p_vs = 1'b1;
    vexp_t       vq[$];
    cexp_t       cq[$];

    vga_tile_renderer dut (
        .clk       (clk),
        .reset     (reset),
        .vaddr     (vaddr),
        .vga_DA    (vga_DA),
        .vga_HS    (vga_HS),
        .vga_VS    (vga_VS),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .out_R     (out_R),
        .out_G     (out_G),
        .out_B     (out_B),
        .out_HS    (out_HS),
        .out_VS    (out_VS),
        .out_DA    (out_DA)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pexp(input logic [31:0] va, input logic da);
        logic [31:0] w;
        w = model[va[8:0]];
        if (!da) return 12'h000;
        return (w[24] && (fcnt % 32) >= 16) ? w[23:12] : w[11:0];
    endfunction

    function automatic logic [31:0] pat(input int i);
        logic [11:0] a, b;
        a = 12'(i ^ 32'h5A5);
        b = 12'(i * 7);
        return {8'h00, a, b};
    endfunction

    // One pixel clock: check what has emerged, then drive the next inputs.
    // da/hs/vs belong to this vaddr and are applied one cycle later.
    task automatic cyc(input logic [31:0] va, input logic da, input logic hs, input logic vs,
                       input logic [11:0] rgb, input logic we, input logic [8:0] idx,
                       input logic [31:0] wd, input logic cchk);
        vexp_t e;
        cexp_t c;
        @(negedge clk);
        if (vq.size() == 2) begin
            e = vq.pop_front();
            total++;
            if ({out_R, out_G, out_B, out_DA, out_HS, out_VS} !== {e.rgb, e.da, e.hs, e.vs}) begin
                bad++;
                $display("FAIL video t=%0t: got rgb=%h da=%b hs=%b vs=%b want rgb=%h da=%b hs=%b vs=%b",
                         $time, {out_R, out_G, out_B}, out_DA, out_HS, out_VS, e.rgb, e.da, e.hs, e.vs);
            end
        end
        if (cq.size() == 1) begin
            c = cq.pop_front();
            if (c.chk) begin
                total++;
                if (cpu_rdata !== c.d) begin
                    bad++;
                    $display("FAIL cpu_rdata t=%0t: got %h want %h", $time, cpu_rdata, c.d);
                end
            end
        end
        vaddr  = va;
        vga_DA = p_da;
        vga_HS = p_hs;
        vga_VS = p_vs;
        p_da = da;
        p_hs = hs;
        p_vs = vs;
        cpu_we    = we;
        cpu_addr  = {21'h0, idx, 2'b00};
        cpu_wdata = wd;
        vq.push_back('{rgb: rgb, da: da, hs: hs, vs: vs});
        cq.push_back('{d: model[idx], chk: cchk});
        if (we) model[idx] = wd;
    endtask

    task automatic vid(input logic [31:0] va, input logic da, input logic [11:0] rgb);
        cyc(va, da, 1'b1, 1'b1, rgb, 1'b0, 9'd0, 32'h0, 1'b1);
    endtask

    task automatic wr(input logic [8:0] idx, input logic [31:0] wd);
        cyc(32'h0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1, idx, wd, 1'b1);
    endtask

    task automatic rd(input logic [8:0] idx);
        cyc(32'h0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, idx, 32'h0, 1'b1);
    endtask

    task automatic check_idle(input string name, input logic [4:0] fc_before);
        total++;
        if ({out_R, out_G, out_B, out_DA, out_HS, out_VS, cpu_rdata, dut.frame_cnt} !==
            {12'h000, 1'b0, 1'b1, 1'b1, 32'h0, 5'd0}) begin
            bad++;
            $display("FAIL %s: got rgb=%h da=%b hs=%b vs=%b rdata=%h fcnt=%0d (was %0d) want all idle",
                     name, {out_R, out_G, out_B}, out_DA, out_HS, out_VS, cpu_rdata,
                     dut.frame_cnt, fc_before);
        end
    endtask

    initial begin
        vec_t tbl [8];
        logic [11:0] old7;

        // Reset state.
        #12;
        check_idle("reset_state", 5'd0);
        @(negedge clk);
        reset = 1'b1;

        // Fill the whole RAM so every later read has a known model value.
        for (int i = 0; i < 512; i++)
            cyc(32'h0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1, 9'(i), pat(i), 1'b0);

        wr(9'd0,   32'h0000_00F0);
        wr(9'd21,  32'h0000_000F);
        wr(9'd5,   32'h0000_0F00);
        wr(9'd299, 32'h0000_0ABC);
        wr(9'd3,   32'h01AB_C123);
        wr(9'd9,   32'hFE00_0555);
        rd(9'd5);
        rd(9'd9);
        rd(9'd299);

        // Pixel vectors: {vaddr, DA for that pixel, expected colour}.
        tbl[0] = '{32'd0,         1'b1, 12'h0F0};
        tbl[1] = '{32'd21,        1'b1, 12'h00F};
        tbl[2] = '{32'd0,         1'b0, 12'h000};
        tbl[3] = '{32'd21,        1'b0, 12'h000};
        tbl[4] = '{32'd345,       1'b0, 12'h000};
        tbl[5] = '{32'h0000_0205, 1'b1, 12'hF00};
        tbl[6] = '{32'hFFFF_FE15, 1'b1, 12'h00F};
        tbl[7] = '{32'd299,       1'b1, 12'hABC};
        for (int i = 0; i < 8; i++)
            vid(tbl[i].va, tbl[i].da, tbl[i].rgb);

        // 96-cycle HS pulse with blanking; scoreboard checks every edge.
        for (int i = 0; i < 3; i++) vid(32'd21, 1'b1, 12'h00F);
        for (int i = 0; i < 96; i++)
            cyc(32'd21, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 9'd0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) vid(32'd0, 1'b1, 12'h0F0);

        // Collision: video and CPU both see the old word in the write cycle.
        old7 = pexp(32'd7, 1'b1);
        cyc(32'd7, 1'b1, 1'b1, 1'b1, old7, 1'b1, 9'd7, 32'h0000_0FFF, 1'b1);
        cyc(32'd7, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b0, 9'd7, 32'h0, 1'b1);
        vid(32'd7, 1'b1, 12'hFFF);

        // Blink: 33 frames, phase flips every 16 VS edges.
        for (int f = 0; f < 34; f++) begin
            for (int i = 0; i < 4; i++)
                vid(32'd3, 1'b1, ((fcnt % 32) >= 16) ? 12'hABC : 12'h123);
            if (f == 33) break;
            fcnt++;
            for (int i = 0; i < 3; i++)
                cyc(32'd300, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 9'd0, 32'h0, 1'b1);
            for (int i = 0; i < 3; i++) vid(32'd320, 1'b0, 12'h000);
        end

        // Reset during active video.
        for (int i = 0; i < 3; i++) vid(32'd0, 1'b1, 12'h0F0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_idle("reset_midframe", 5'(fcnt));
        vq.delete();
        cq.delete();
        p_da = 1'b0; p_hs = 1'b1; p_vs = 1'b1;
        vaddr = 32'h0; vga_DA = 1'b0; vga_HS = 1'b1; vga_VS = 1'b1; cpu_we = 1'b0;
        fcnt = 0;
        @(negedge clk);
        #1 reset = 1'b1;

        rd(9'd5);
        rd(9'd3);
        vid(32'd21, 1'b1, 12'h00F);
        vid(32'd7,  1'b1, 12'hFFF);
        vid(32'd3,  1'b1, 12'h123);
        rd(9'd0);
        rd(9'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
